// File: rtl/std_seq_ctrl.sv
// -----------------------------------------------------------------------------
// std_seq_ctrl -- sequences up to STAGES child units, one at a time.
//
// A go in IDLE captures the stage-enable mask and starts the lowest enabled
// stage. Each active stage is given a one-hot child_go until its child_done
// bit is seen. The controller then moves to the next higher enabled stage.
// After the last enabled stage it emits a one-cycle done pulse and returns to
// IDLE.
//
// Optional feature (macro SEQ_CTRL_TIMEOUT_EN):
//   Adds a per-stage watchdog. If a stage waits TIMEOUT cycles without its
//   child_done, the controller locks in ERR with err=1 until reset. Without
//   the macro there is no counter, no ERR state, and err is tied low.
//
// Parameters:
//   STAGES  : number of child units, 2..16
//   TIMEOUT : watchdog limit in cycles (>= 1, used only with the macro)
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous reset, active low
//   go         : start request, level-sampled in IDLE
//   mask       : [STAGES] stage enables, captured when go is accepted
//   child_done : [STAGES] done flags from the children
//   child_go   : [STAGES] one-hot go to the active child, zero otherwise
//   done       : one-cycle completion pulse
//   busy       : high in any state other than IDLE
//   stage      : [$clog2(STAGES)] active stage index, 0 when not running
//   err        : sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module std_seq_ctrl #(
  parameter int STAGES  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic [STAGES-1:0]         mask,
  input  logic [STAGES-1:0]         child_done,
  output logic [STAGES-1:0]         child_go,
  output logic                      done,
  output logic                      busy,
  output logic [$clog2(STAGES)-1:0] stage,
  output logic                      err
);

  localparam int SW = $clog2(STAGES);

  // Elaboration-time guard on the legal parameter ranges.
  if (STAGES < 2 || STAGES > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("std_seq_ctrl: STAGES must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
`ifdef SEQ_CTRL_TIMEOUT_EN
    ,
    ERR  = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [STAGES-1:0] mask_q,  mask_d;
  logic [SW:0]       nxt;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
`endif

  // Lowest set bit of m whose index is >= lo. The MSB of the result flags
  // whether such a bit exists; lo is one bit wider than a stage index so that
  // "last stage + 1" does not wrap back to 0.
  function automatic logic [SW:0] next_bit(input logic [STAGES-1:0] m,
                                           input logic [SW:0]       lo);
    logic [SW:0] r;
    r = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) begin
        r = {1'b1, SW'(i)};
      end
    end
    return r;
  endfunction

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      mask_q  <= '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mask_q  <= mask_d;
`ifdef SEQ_CTRL_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mask_d  = mask_q;
    nxt     = '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        stage_d = '0;
        if (go) begin
          mask_d = mask;
          nxt    = next_bit(mask, '0);
          if (nxt[SW]) begin
            state_d = RUN;
            stage_d = nxt[SW-1:0];
`ifdef SEQ_CTRL_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Empty mask: nothing to run, report completion directly.
            state_d = FIN;
          end
        end
      end

      RUN: begin
        // Only the active child's done flag matters; the others are ignored.
        if (child_done[stage_q]) begin
          nxt = next_bit(mask_q, {1'b0, stage_q} + 1'b1);
          if (nxt[SW]) begin
            stage_d = nxt[SW-1:0];
`ifdef SEQ_CTRL_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = FIN;
            stage_d = '0;
          end
        end
`ifdef SEQ_CTRL_TIMEOUT_EN
        else begin
          // This cycle is the TIMEOUT-th consecutive wait: give up.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = ERR;
            stage_d = '0;
          end
        end
`endif
      end

      FIN: begin
        // go is not looked at here; a held go is taken again from IDLE.
        state_d = IDLE;
        stage_d = '0;
      end

`ifdef SEQ_CTRL_TIMEOUT_EN
      ERR: begin
        // Locked until reset.
        state_d = ERR;
        stage_d = '0;
      end
`endif

      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only, so go and child_done have
  // no combinational path to child_go.
  always_comb begin
    child_go = '0;
    if (state_q == RUN) begin
      child_go = {{(STAGES-1){1'b0}}, 1'b1} << stage_q;
    end
    done  = (state_q == FIN);
    busy  = (state_q != IDLE);
    stage = stage_q;
`ifdef SEQ_CTRL_TIMEOUT_EN
    err   = (state_q == ERR);
`else
    err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_std_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_std_seq_ctrl -- directed self-checking bench for std_seq_ctrl.
// STAGES=4, TIMEOUT=8. "Cycle n" is the interval after the n-th rising edge
// following the cycle in which go is raised (cycle 0). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_std_seq_ctrl;

  localparam int STAGES  = 4;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              reset;
  logic              go;
  logic [STAGES-1:0] mask;
  logic [STAGES-1:0] child_done;
  logic [STAGES-1:0] child_go;
  logic              done;
  logic              busy;
  logic [1:0]        stage;
  logic              err;

  int n_vec;
  int n_err;

  std_seq_ctrl #(
    .STAGES  (STAGES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .mask       (mask),
    .child_done (child_done),
    .child_go   (child_go),
    .done       (done),
    .busy       (busy),
    .stage      (stage),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Check every output against its expected value.
  task automatic chk_out(input string tag, input logic [3:0] e_go,
                         input logic e_done, input logic e_busy,
                         input logic [1:0] e_stage, input logic e_err);
    chk({tag, ".child_go"}, 32'(child_go), 32'(e_go));
    chk({tag, ".done"},     32'(done),     32'(e_done));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".stage"},    32'(stage),    32'(e_stage));
    chk({tag, ".err"},      32'(err),      32'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b0;
    go         = 1'b0;
    mask       = '0;
    child_done = '0;

    // Reset state
    tick(); tick();
    chk_out("rst", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // All four stages, each child done on its first go cycle
    mask = 4'b1111; child_done = 4'b1111; go = 1'b1;
    tick(); go = 1'b0;
    chk_out("all.c1", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    tick(); chk_out("all.c2", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    tick(); chk_out("all.c3", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    tick(); chk_out("all.c4", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    tick(); chk_out("all.c5", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    tick(); chk_out("all.c6", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Sparse mask 1010, child 1 done after 3 cycles; mask changed mid-run
    mask = 4'b1010; child_done = 4'b0000; go = 1'b1;
    tick(); go = 1'b0; mask = 4'b0101;
    chk_out("sp.c1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    tick(); chk_out("sp.c2", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    tick(); chk_out("sp.c3", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    child_done = 4'b0010;
    tick(); chk_out("sp.c4", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    child_done = 4'b1000;
    tick(); chk_out("sp.c5", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0000;
    tick(); chk_out("sp.c6", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Empty mask: done the cycle after go
    mask = 4'b0000; go = 1'b1;
    tick(); go = 1'b0;
    chk_out("empty.c1", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    tick(); chk_out("empty.c2", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // go held high, spurious child_done[0] while at stage 2, restart after FIN
    mask = 4'b0101; child_done = 4'b0000; go = 1'b1;
    tick(); chk_out("hold.c1", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0001;
    tick(); chk_out("hold.c2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    tick(); chk_out("hold.c3", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    child_done = 4'b0100;
    tick(); chk_out("hold.c4", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0000;
    tick(); chk_out("hold.c5", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tick(); chk_out("hold.c6", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    go = 1'b0; child_done = 4'b0101;
    tick(); chk_out("hold.c7", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    tick(); chk_out("hold.c8", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0000;
    tick(); chk_out("hold.c9", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset pulse while at stage 1, then restart from lowest set bit
    mask = 4'b0110; go = 1'b1;
    tick(); go = 1'b0;
    chk_out("mrst.c1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    reset = 1'b0;
    tick(); reset = 1'b1;
    chk_out("mrst.c2", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tick(); chk_out("mrst.c3", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    go = 1'b1;
    tick(); go = 1'b0; child_done = 4'b0110;
    chk_out("mrst.c4", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    tick(); chk_out("mrst.c5", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    tick(); chk_out("mrst.c6", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0000;
    tick(); chk_out("mrst.c7", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Child 0 never answers
    mask = 4'b0001; child_done = 4'b0000; go = 1'b1;
    tick(); go = 1'b0;
    chk_out("wd.c1", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
`ifdef SEQ_CTRL_TIMEOUT_EN
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick(); chk_out("wd.run", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    end
    tick(); chk_out("wd.err", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1);
    go = 1'b1; child_done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out("wd.lock", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1);
    end
    go = 1'b0; child_done = 4'b0000;
`else
    for (int i = 2; i <= 110; i++) begin
      tick(); chk_out("wd.wait", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    end
    // Child finally answers: sequence still completes normally
    child_done = 4'b0001;
    tick(); chk_out("wd.fin", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    child_done = 4'b0000;
`endif
    reset = 1'b0;
    tick(); reset = 1'b1;
    chk_out("wd.rst", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
